// File: rtl/seg_scan_drv_pkg.sv
// Shared display package: 7-segment pattern table, cathode bit order and
// the cathode packing helper used by every multiplexed-display top level.
package seg_scan_drv_pkg;

  localparam int SEG_W = 7;
  localparam int CAT_W = 8;

  // Segment bit positions inside a {a,b,c,d,e,f,g} pattern
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Cathode bit positions inside dec_cat = {a,b,c,d,e,f,g,dp}
  localparam int CAT_A  = 7;
  localparam int CAT_B  = 6;
  localparam int CAT_C  = 5;
  localparam int CAT_D  = 4;
  localparam int CAT_E  = 3;
  localparam int CAT_F  = 2;
  localparam int CAT_G  = 1;
  localparam int CAT_DP = 0;

  typedef enum logic {
    BLINK_OFF = 1'b0,
    BLINK_ON  = 1'b1
  } blink_phase_e;

  // Active-high {a..g} patterns for hex digits 0-F
  localparam logic [SEG_W-1:0] SEG7_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic [CAT_W-1:0] cat_pack(input logic [SEG_W-1:0] seg,
                                                input logic             dp,
                                                input logic             dark);
    logic [CAT_W-1:0] cat;
    cat = {CAT_W{1'b1}};
    if (!dark) begin
      cat[CAT_A]  = ~seg[SEG_A];
      cat[CAT_B]  = ~seg[SEG_B];
      cat[CAT_C]  = ~seg[SEG_C];
      cat[CAT_D]  = ~seg[SEG_D];
      cat[CAT_E]  = ~seg[SEG_E];
      cat[CAT_F]  = ~seg[SEG_F];
      cat[CAT_G]  = ~seg[SEG_G];
      cat[CAT_DP] = ~dp;
    end else begin
      cat = {CAT_W{1'b1}};
    end
    return cat;
  endfunction

endpackage

// File: rtl/seg_scan_drv_if.sv
// Update bus of the scanned display driver: digit data, attributes,
// the capture strobe and its acknowledge.
interface seg_scan_drv_if #(
  parameter int N_DIG = 8
);
  import seg_scan_drv_pkg::*;

  logic [4*N_DIG-1:0] dig_val;
  logic [N_DIG-1:0]   dig_en;
  logic [N_DIG-1:0]   dp_in;
  logic [N_DIG-1:0]   blink_in;
  logic               lzb_in;
  logic               upd;
  logic               upd_ack;

  modport master (
    output dig_val, dig_en, dp_in, blink_in, lzb_in, upd,
    input  upd_ack
  );

  modport slave (
    input  dig_val, dig_en, dp_in, blink_in, lzb_in, upd,
    output upd_ack
  );

endinterface

// File: rtl/seg_scan_drv_seg7_dec.sv
// Combinational hex nibble to active-high {a..g} segment decoder.
module seg7_dec
  import seg_scan_drv_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg
);

  // Table lookup of the segment pattern
  always_comb begin
    seg = SEG7_TABLE[hex];
  end

endmodule

// File: rtl/seg_scan_drv.sv
// Multiplexed 7-segment scan driver with double-buffered, frame-aligned
// updates, leading-zero blanking and per-digit blink.
module seg_scan_drv
  import seg_scan_drv_pkg::*;
#(
  parameter int N_DIG        = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic             clk,
  input  logic             rst,
  seg_scan_drv_if.slave    bus,
  output logic [N_DIG-1:0] an,
  output logic [CAT_W-1:0] dec_cat,
  output logic             frame_done
);

  localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIG - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1'b1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1'b1);
  localparam logic [BLK_W-1:0]  BLK_ONE   = BLK_W'(1'b1);

  logic [SLOT_W-1:0]  slot_cnt_r, slot_nxt_s;
  logic [IDX_W-1:0]   idx_r, idx_nxt_s;
  logic [BLK_W-1:0]   blink_cnt_r;
  blink_phase_e       blink_phase_r;
  logic               frame_done_r;

  logic               pend_flag_r;
  logic [4*N_DIG-1:0] pend_val_r, act_val_r;
  logic [N_DIG-1:0]   pend_en_r, act_en_r;
  logic [N_DIG-1:0]   pend_dp_r, act_dp_r;
  logic [N_DIG-1:0]   pend_blink_r, act_blink_r;
  logic               pend_lzb_r, act_lzb_r;

  logic [N_DIG-1:0]   lz_blank_s, dark_s, anode_s;
  logic [3:0]         cur_val_s;
  logic               cur_dark_s, cur_dp_s, xfer_s;
  logic [SEG_W-1:0]   seg_s;
  logic [N_DIG-1:0]   an_r;
  logic [CAT_W-1:0]   dec_cat_r;

  // The transfer fires on the frame's last cycle, so frame_done and the ack coincide
  assign xfer_s      = frame_done_r & (pend_flag_r | bus.upd);
  assign bus.upd_ack = xfer_s;
  assign an          = an_r;
  assign dec_cat     = dec_cat_r;
  assign frame_done  = frame_done_r;

  // Next slot counter and scan index
  always_comb begin
    slot_nxt_s = slot_cnt_r + SLOT_ONE;
    idx_nxt_s  = idx_r;
    if (slot_cnt_r == SLOT_LAST) begin
      slot_nxt_s = {SLOT_W{1'b0}};
      idx_nxt_s  = (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_ONE;
    end else begin
      slot_nxt_s = slot_cnt_r + SLOT_ONE;
    end
  end

  // Slot timer, scan index, look-ahead frame strobe and blink phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_r    <= {SLOT_W{1'b0}};
      idx_r         <= {IDX_W{1'b0}};
      frame_done_r  <= 1'b0;
      blink_cnt_r   <= {BLK_W{1'b0}};
      blink_phase_r <= BLINK_ON;
    end else begin
      slot_cnt_r   <= slot_nxt_s;
      idx_r        <= idx_nxt_s;
      frame_done_r <= (slot_nxt_s == SLOT_LAST) && (idx_nxt_s == IDX_LAST);
      if (frame_done_r) begin
        if (blink_cnt_r == BLK_LAST) begin
          blink_cnt_r   <= {BLK_W{1'b0}};
          blink_phase_r <= (blink_phase_r == BLINK_ON) ? BLINK_OFF : BLINK_ON;
        end else begin
          blink_cnt_r <= blink_cnt_r + BLK_ONE;
        end
      end
    end
  end

  // Pending capture and frame-aligned copy into the active buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_flag_r  <= 1'b0;
      pend_val_r   <= {(4*N_DIG){1'b0}};
      pend_en_r    <= {N_DIG{1'b0}};
      pend_dp_r    <= {N_DIG{1'b0}};
      pend_blink_r <= {N_DIG{1'b0}};
      pend_lzb_r   <= 1'b0;
      act_val_r    <= {(4*N_DIG){1'b0}};
      act_en_r     <= {N_DIG{1'b0}};
      act_dp_r     <= {N_DIG{1'b0}};
      act_blink_r  <= {N_DIG{1'b0}};
      act_lzb_r    <= 1'b0;
    end else begin
      if (bus.upd) begin
        pend_val_r   <= bus.dig_val;
        pend_en_r    <= bus.dig_en;
        pend_dp_r    <= bus.dp_in;
        pend_blink_r <= bus.blink_in;
        pend_lzb_r   <= bus.lzb_in;
      end
      if (xfer_s) begin
        pend_flag_r <= 1'b0;
        act_val_r   <= bus.upd ? bus.dig_val  : pend_val_r;
        act_en_r    <= bus.upd ? bus.dig_en   : pend_en_r;
        act_dp_r    <= bus.upd ? bus.dp_in    : pend_dp_r;
        act_blink_r <= bus.upd ? bus.blink_in : pend_blink_r;
        act_lzb_r   <= bus.upd ? bus.lzb_in   : pend_lzb_r;
      end else if (bus.upd) begin
        pend_flag_r <= 1'b1;
      end
    end
  end

  // Leading-zero search from the top digit; disabled digits do not end the run
  always_comb begin
    logic lead_s;
    lead_s     = 1'b1;
    lz_blank_s = {N_DIG{1'b0}};
    for (int i = N_DIG - 1; i >= 1; i--) begin
      lz_blank_s[i] = act_lzb_r & lead_s & act_en_r[i] & (act_val_r[4*i +: 4] == 4'h0);
      lead_s        = lead_s & ~(act_en_r[i] & (act_val_r[4*i +: 4] != 4'h0));
    end
    dark_s = ~act_en_r | lz_blank_s |
             (act_blink_r & {N_DIG{blink_phase_r == BLINK_OFF}});
  end

  // Attributes of the digit under the scan index
  always_comb begin
    cur_val_s  = act_val_r[{idx_r, 2'b00} +: 4];
    cur_dark_s = dark_s[idx_r];
    cur_dp_s   = act_dp_r[idx_r];
    anode_s          = {N_DIG{1'b1}};
    anode_s[idx_r]   = cur_dark_s;
  end

  seg7_dec u_seg7_dec (
    .hex (cur_val_s),
    .seg (seg_s)
  );

  // Anode and cathode registers load together so no mixed frame is visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_r      <= {N_DIG{1'b1}};
      dec_cat_r <= {CAT_W{1'b1}};
    end else begin
      an_r      <= anode_s;
      dec_cat_r <= cat_pack(seg_s, cur_dp_s, cur_dark_s);
    end
  end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Randomised and scenario bench for seg_scan_drv against a frame-level
// reference model (N_DIG=4, REFRESH_DIV=4, BLINK_FRAMES=2).
module tb_seg_scan_drv;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BF = 2;
  localparam int FR = N * RD;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  en;
    logic [3:0]  dp;
    logic [3:0]  blink;
    logic        lzb;
  } cfg_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] an;
  logic [7:0] dec_cat;
  logic       frame_done;

  seg_scan_drv_if #(.N_DIG(N)) bus ();

  seg_scan_drv #(.N_DIG(N), .REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .an         (an),
    .dec_cat    (dec_cat),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  string segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  int   n_vec = 0;
  int   n_err = 0;
  int   e     = 0;     // clock edges since reset release
  int   acks  = 0;
  cfg_t in_cfg, p_cfg, a_cfg;
  bit   p_flag;
  logic [3:0] last_an;
  logic [7:0] last_cat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  function automatic logic [7:0] cat_model(input logic [3:0] v, input logic dp, input bit dark);
    logic [7:0] lit;
    string s;
    if (dark) return 8'hFF;
    lit = 8'h00;
    s = segs[v];
    for (int j = 0; j < s.len(); j++) lit[7 - (int'(s[j]) - 97)] = 1'b1;
    lit[0] = dp;
    return ~lit;
  endfunction

  function automatic bit dark_model(input int i, input int frame);
    int top;
    bit on_phase, lz;
    top = -1;
    for (int d = 0; d < N; d++)
      if (a_cfg.en[d] && a_cfg.val[d*4 +: 4] != 4'h0) top = d;
    on_phase = ((frame / BF) % 2) == 0;
    lz = a_cfg.lzb && (i > 0) && (i > top) && (a_cfg.val[i*4 +: 4] == 4'h0);
    return !a_cfg.en[i] || lz || (a_cfg.blink[i] && !on_phase);
  endfunction

  task automatic cyc(input logic u);
    int idx;
    bit dk, fd_exp, ack_exp;
    logic [3:0] an_exp;
    logic [7:0] cat_exp;
    @(negedge clk);
    bus.dig_val  = in_cfg.val;
    bus.dig_en   = in_cfg.en;
    bus.dp_in    = in_cfg.dp;
    bus.blink_in = in_cfg.blink;
    bus.lzb_in   = in_cfg.lzb;
    bus.upd      = u;
    #1;
    fd_exp  = (e % FR) == FR - 1;
    ack_exp = fd_exp && (p_flag || u);
    check_eq("frame_done", 32'(frame_done), 32'(fd_exp));
    check_eq("upd_ack", 32'(bus.upd_ack), 32'(ack_exp));
    if (bus.upd_ack) acks++;
    idx     = (e / RD) % N;
    dk      = dark_model(idx, e / FR);
    an_exp  = 4'hF;
    if (!dk) an_exp[idx] = 1'b0;
    cat_exp = cat_model(a_cfg.val[idx*4 +: 4], a_cfg.dp[idx], dk);
    if (ack_exp) begin
      a_cfg  = u ? in_cfg : p_cfg;
      p_flag = 1'b0;
    end else if (u) begin
      p_flag = 1'b1;
    end
    if (u) p_cfg = in_cfg;
    e++;
    @(posedge clk);
    #1;
    check_eq("an", 32'(an), 32'(an_exp));
    check_eq("dec_cat", 32'(dec_cat), 32'(cat_exp));
    last_an  = an;
    last_cat = dec_cat;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst     = 1'b1;
    bus.upd = 1'b0;
    #1;
    check_eq("rst_an", 32'(an), 32'hF);
    check_eq("rst_cat", 32'(dec_cat), 32'hFF);
    check_eq("rst_ack", 32'(bus.upd_ack), 32'h0);
    check_eq("rst_fd", 32'(frame_done), 32'h0);
    @(posedge clk);
    #1;
    check_eq("rst_an_hold", 32'(an), 32'hF);
    rst    = 1'b0;
    e      = 0;
    p_flag = 1'b0;
    p_cfg  = '0;
    a_cfg  = '0;
  endtask

  task automatic run_to_frame_start();
    for (int k = 0; k < FR && (e % FR) != 0; k++) cyc(1'b0);
  endtask

  initial begin
    int a0;
    rst = 1'b1;
    bus.dig_val = '0; bus.dig_en = '0; bus.dp_in = '0;
    bus.blink_in = '0; bus.lzb_in = 1'b0; bus.upd = 1'b0;
    in_cfg = '0; p_cfg = '0; a_cfg = '0; p_flag = 1'b0;
    @(posedge clk);
    #1;
    check_eq("init_an", 32'(an), 32'hF);
    check_eq("init_cat", 32'(dec_cat), 32'hFF);
    check_eq("init_fd", 32'(frame_done), 32'h0);
    check_eq("init_ack", 32'(bus.upd_ack), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic scan of 1234
    in_cfg = '{val: 16'h1234, en: 4'hF, dp: 4'h0, blink: 4'h0, lzb: 1'b0};
    cyc(1'b1);
    repeat (16) cyc(1'b0);
    check_eq("scan_an0", 32'(last_an), 32'hE);
    check_eq("scan_cat4", 32'(last_cat), 32'h99);
    repeat (15) cyc(1'b0);

    // Leading-zero blanking
    in_cfg.val = 16'h0050; in_cfg.lzb = 1'b1;
    cyc(1'b1);
    repeat (31) cyc(1'b0);
    in_cfg.val = 16'h0000;
    cyc(1'b1);
    repeat (31) cyc(1'b0);

    // Two updates in one frame: last wins, one ack
    run_to_frame_start();
    in_cfg = '{val: 16'hAAAA, en: 4'hF, dp: 4'h0, blink: 4'h0, lzb: 1'b0};
    a0 = acks;
    cyc(1'b1);
    repeat (7) cyc(1'b0);
    in_cfg.val = 16'hBBBB;
    cyc(1'b1);
    run_to_frame_start();
    check_eq("tear_acks", 32'(acks - a0), 32'd1);
    cyc(1'b0);
    check_eq("tear_cat_b", 32'(last_cat), 32'hC1);
    repeat (15) cyc(1'b0);

    // Update strobe on the frame_done cycle
    for (int k = 0; k < FR && (e % FR) != FR - 1; k++) cyc(1'b0);
    in_cfg.val = 16'hCDEF;
    a0 = acks;
    cyc(1'b1);
    check_eq("coin_ack", 32'(acks - a0), 32'd1);
    cyc(1'b0);
    check_eq("coin_cat_f", 32'(last_cat), 32'h71);

    // Blink on digit 0 across five frames from reset
    do_reset();
    in_cfg = '{val: 16'h1234, en: 4'hF, dp: 4'b0101, blink: 4'b0001, lzb: 1'b0};
    cyc(1'b1);
    repeat (79) cyc(1'b0);

    // Reset while digit 2 is shown and an update is pending
    for (int k = 0; k < 64 && last_an != 4'b1011; k++) cyc(1'b0);
    check_eq("mid_dig2", 32'(last_an), 32'hB);
    in_cfg.val = 16'h5678;
    cyc(1'b1);
    a0 = acks;
    do_reset();
    repeat (48) cyc(1'b0);
    check_eq("mid_no_ack", 32'(acks - a0), 32'd0);
    check_eq("mid_dark", 32'(last_an), 32'hF);

    // Random traffic, including input churn without upd
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int d = 0; d < N; d++)
          in_cfg.val[d*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        in_cfg.en    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        in_cfg.dp    = 4'($urandom);
        in_cfg.blink = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        in_cfg.lzb   = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      else cyc($urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_drv.md
SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

Interface
REQ-001 The block SHALL have parameter N_DIG, default 8: number of multiplexed digits, legal range 1..16.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000: clk cycles per digit slot, legal minimum 2; at 100 MHz this gives 1 kHz per digit.
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 64: scan frames per blink half-period, legal minimum 1.
REQ-004 clk  in  1  system clock, 100 MHz, single clock domain.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 dig_val  in  4*N_DIG  hex nibble per digit; digit 0 is the LSBs and the rightmost display.
REQ-007 dig_en  in  N_DIG  per-digit enable; 0 turns the digit dark.
REQ-008 dp_in  in  N_DIG  per-digit decimal point, 1 lights the point.
REQ-009 blink_in  in  N_DIG  per-digit blink enable.
REQ-010 lzb_in  in  1  leading-zero blanking enable.
REQ-011 upd  in  1  single-cycle strobe; captures all dig_*/dp_in/blink_in/lzb_in inputs into the pending buffer.
REQ-012 upd_ack  out  1  single-cycle pulse when the pending buffer is copied to the active buffer.
REQ-013 an  out  N_DIG  anode selects, active-low.
REQ-014 dec_cat  out  8  cathodes {a,b,c,d,e,f,g,dp}, active-low.
REQ-015 frame_done  out  1  single-cycle pulse when the scan index wraps from N_DIG-1 to 0.

Function
REQ-016 The slot counter SHALL count 0..REFRESH_DIV-1; at terminal count it SHALL reset to 0 and advance the scan index by 1 modulo N_DIG.
REQ-017 Counter widths SHALL be $clog2 of their range and at least 1 bit; wrap-around SHALL NOT produce out-of-range indices.
REQ-018 Exactly one an bit SHALL be low during each slot: the bit for the current index. The exception is a dark digit, which drives all an high for that slot.
REQ-019 A digit SHALL be dark when any of the following holds: its active dig_en=0; it is leading-zero blanked; blink is in its off phase and its blink bit is set.
REQ-020 Leading-zero blanking: with lzb=1, digits from index N_DIG-1 downward whose value is 0 SHALL be blanked up to the first nonzero enabled digit. Digit 0 SHALL never be LZ-blanked. Disabled digits SHALL be skipped when searching for the first nonzero digit.
REQ-021 dec_cat SHALL decode the hex value 0-F to standard 7-segment patterns. The dp segment SHALL be lit iff dp=1 and the digit is not dark.
REQ-022 an and dec_cat SHALL be registered outputs, updated 1 cycle after the scan index changes. Both SHALL change in the same cycle, with no intermediate values.
REQ-023 Blink phase SHALL toggle every BLINK_FRAMES frame_done pulses and SHALL start in the on phase after reset.
REQ-024 upd SHALL set a pending flag. A second upd before transfer SHALL overwrite the pending buffer; last value wins.
REQ-025 The pending-to-active transfer SHALL occur in the cycle frame_done is asserted, and only if the pending flag is set; upd_ack SHALL pulse in that same cycle.
REQ-026 If upd and frame_done coincide, the new data SHALL be captured and transferred on that frame boundary, with upd_ack asserted.
REQ-027 Input changes without upd SHALL have no effect on the displayed output; this prevents tearing mid-frame.

Reset
REQ-028 While rst=1, outputs SHALL be: an all 1, dec_cat 8'hFF, upd_ack 0, frame_done 0.
REQ-029 While rst=1, internal state SHALL be: slot counter 0, scan index 0, blink counter 0 with phase on, pending flag 0, active and pending buffers all zero (all digits disabled).
REQ-030 Reset asserted mid-operation SHALL discard any pending update without pulsing upd_ack.
REQ-031 After reset is released, digit 0's first slot SHALL begin on the next clk edge.

Structure
REQ-032 The 7-segment pattern table and the cathode bit-order constants SHALL reside in the shared display package. This package is also used by the timer and Fibonacci top-levels.
REQ-033 Hex-to-segment decode SHALL be a separate combinational sub-module named seg7_dec. All counters, buffers and blanking logic SHALL stay in seg_scan_drv.

Verification
All scenarios use N_DIG=4, REFRESH_DIV=4, BLINK_FRAMES=2.
REQ-034 Scan: after reset, upd with val=16'h1234 and dig_en=4'hF, then wait one frame. Expect an to cycle 1110,1101,1011,0111 with 4 cycles each; dec_cat patterns for 4,3,2,1; upd_ack and frame_done pulse together.
REQ-035 LZ blank: val=16'h0050, en=F, lzb=1. Expect digits 3 and 2 dark. Then val=0: expect only digit 0 lit, showing "0".
REQ-036 Tear-free: upd with 16'hAAAA, then upd with 16'hBBBB mid-frame. Expect the next frame to show all "b" and a single upd_ack.
REQ-037 Blink: blink_in=4'b0001. Expect digit 0 lit for frames 0-1, dark for frames 2-3, lit again at frame 4; other digits always lit.
REQ-038 Reset mid-frame: assert rst while digit 2 is active and an update is pending. Expect an=4'hF and dec_cat=8'hFF immediately with no upd_ack; after release, all digits stay dark until the next upd.
REQ-039 Coincidence: upd in the same cycle as frame_done. Expect the transfer on that edge and an upd_ack pulse in that cycle.
